// File: rtl/onehot_arbiter_mux_pkg.sv
// onehot_arbiter_mux_pkg: shared arbitration policy type
package onehot_arbiter_mux_pkg;
    typedef enum logic {
        ARB_ROUND_ROBIN = 1'b0,
        ARB_FIXED       = 1'b1
    } arb_mode_t;
endpackage

// File: rtl/onehot_arbiter_mux_onehot_mux.sv
// onehot_mux: AND-OR word select driven by a one-hot (or zero) select vector
module onehot_mux #(
    parameter int Count = 4,
    parameter int Width = 32
) (
    input  logic [Count-1:0] sel,
    input  logic [Width-1:0] din [Count],
    output logic [Width-1:0] dout
);
    always_comb begin
        dout = '0;
        for (int i = 0; i < Count; i++) dout = dout | (din[i] & {Width{sel[i]}});
    end
endmodule

// File: rtl/onehot_arbiter_mux.sv
// onehot_arbiter_mux: fixed/round-robin arbiter selecting one request word into a single-entry output register
module onehot_arbiter_mux
    import onehot_arbiter_mux_pkg::*;
#(
    parameter int        Count = 4,
    parameter int        Width = 32,
    parameter arb_mode_t Mode  = ARB_ROUND_ROBIN
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Count-1:0] req_valid_i,
    input  logic [Width-1:0] req_word_i [Count],
    output logic [Count-1:0] req_ready_o,
    output logic             word_valid_o,
    output logic [Width-1:0] word_o,
    output logic [Count-1:0] grant_o,
    input  logic             word_ready_i
);
    logic [Count-1:0] ptr, masked, pick, grant, ptr_nxt;
    logic [Width-1:0] sel_word;
    logic             can_accept, xfer;

    // Requests at or above the pointer win first; otherwise fall back to lowest index
    always_comb begin
        masked      = req_valid_i & ~(ptr - Count'(1));
        pick        = (Mode == ARB_ROUND_ROBIN && masked != '0) ? masked : req_valid_i;
        grant       = pick & (~pick + Count'(1));
        ptr_nxt     = (grant << 1) | (grant >> (Count - 1));
        can_accept  = !word_valid_o || word_ready_i;
        req_ready_o = grant & {Count{can_accept && rst_ni}};
        xfer        = |req_ready_o;
    end

    onehot_mux #(.Count(Count), .Width(Width)) u_mux (
        .sel  (grant),
        .din  (req_word_i),
        .dout (sel_word)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            word_valid_o <= 1'b0;
            word_o       <= '0;
            grant_o      <= '0;
            ptr          <= Count'(1);
        end else if (xfer) begin
            word_valid_o <= 1'b1;
            word_o       <= sel_word;
            grant_o      <= grant;
            if (Mode == ARB_ROUND_ROBIN) ptr <= ptr_nxt;
        end else if (word_ready_i) begin
            word_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_onehot_arbiter_mux.sv
// tb_onehot_arbiter_mux: vector table plus scoreboard for round-robin, fixed and single-channel variants
module tb_onehot_arbiter_mux;
    import onehot_arbiter_mux_pkg::*;

    typedef struct {
        logic        f;
        logic        rst_n;
        logic [3:0]  v;
        logic        wr;
        logic [3:0]  rdy;
        logic        wv;
        logic [31:0] word;
        logic [3:0]  g;
    } vec_t;

    typedef struct {
        logic        f;
        logic        wv;
        logic [31:0] word;
        logic [3:0]  g;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  v = '0;
    logic        wr = 1'b0;
    logic [31:0] words [4];
    logic [31:0] w1 [1];
    logic [3:0]  r_rdy, r_g, f_rdy, f_g;
    logic        r_wv, f_wv, s_rdy, s_wv, s_g;
    logic [31:0] r_word, f_word, s_word;
    int          total = 0;
    int          passed = 0;
    vec_t        tbl [27];
    exp_t        sb [$];
    exp_t        e;

    always #5 clk = ~clk;

    assign words[0] = 32'hA0;
    assign words[1] = 32'hA1;
    assign words[2] = 32'hA2;
    assign words[3] = 32'hA3;
    assign w1[0]    = 32'h55;

    onehot_arbiter_mux #(.Count(4), .Width(32), .Mode(ARB_ROUND_ROBIN)) u_rr (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v), .req_word_i(words),
        .req_ready_o(r_rdy), .word_valid_o(r_wv), .word_o(r_word), .grant_o(r_g),
        .word_ready_i(wr)
    );

    onehot_arbiter_mux #(.Count(4), .Width(32), .Mode(ARB_FIXED)) u_fx (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v), .req_word_i(words),
        .req_ready_o(f_rdy), .word_valid_o(f_wv), .word_o(f_word), .grant_o(f_g),
        .word_ready_i(wr)
    );

    onehot_arbiter_mux #(.Count(1), .Width(32), .Mode(ARB_ROUND_ROBIN)) u_one (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v[0]), .req_word_i(w1),
        .req_ready_o(s_rdy), .word_valid_o(s_wv), .word_o(s_word), .grant_o(s_g),
        .word_ready_i(wr)
    );

    always @(negedge clk) begin
        if (!$onehot0(r_rdy) || !$onehot0(f_rdy) || !$onehot0(r_g) || !$onehot0(f_g)) begin
            $display("FAIL onehot0 r_rdy=%b f_rdy=%b r_g=%b f_g=%b", r_rdy, f_rdy, r_g, f_g);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic r, input logic [3:0] vv, input logic w);
        @(negedge clk);
        rst_n = r;
        v     = vv;
        wr    = w;
        #1;
    endtask

    initial begin
        tbl = '{
            // reset then idle, valids during reset are ignored
            '{0, 0, 4'b1111, 1, 4'b0000, 0, 32'h00, 4'b0000},
            '{0, 0, 4'b0000, 1, 4'b0000, 0, 32'h00, 4'b0000},
            '{0, 1, 4'b0000, 0, 4'b0000, 0, 32'h00, 4'b0000},
            // round robin rotation, full throughput
            '{0, 1, 4'b1111, 1, 4'b0001, 1, 32'hA0, 4'b0001},
            '{0, 1, 4'b1111, 1, 4'b0010, 1, 32'hA1, 4'b0010},
            '{0, 1, 4'b1111, 1, 4'b0100, 1, 32'hA2, 4'b0100},
            '{0, 1, 4'b1111, 1, 4'b1000, 1, 32'hA3, 4'b1000},
            '{0, 1, 4'b1111, 1, 4'b0001, 1, 32'hA0, 4'b0001},
            // five-cycle stall
            '{0, 1, 4'b1111, 0, 4'b0000, 1, 32'hA0, 4'b0001},
            '{0, 1, 4'b1111, 0, 4'b0000, 1, 32'hA0, 4'b0001},
            '{0, 1, 4'b1111, 0, 4'b0000, 1, 32'hA0, 4'b0001},
            '{0, 1, 4'b1111, 0, 4'b0000, 1, 32'hA0, 4'b0001},
            '{0, 1, 4'b1111, 0, 4'b0000, 1, 32'hA0, 4'b0001},
            '{0, 1, 4'b1111, 1, 4'b0010, 1, 32'hA1, 4'b0010},
            // consume without refill holds data
            '{0, 1, 4'b0000, 1, 4'b0000, 0, 32'hA1, 4'b0010},
            // move pointer to channel 3 and wrap
            '{0, 1, 4'b0100, 1, 4'b0100, 1, 32'hA2, 4'b0100},
            '{0, 1, 4'b1001, 1, 4'b1000, 1, 32'hA3, 4'b1000},
            '{0, 1, 4'b1001, 1, 4'b0001, 1, 32'hA0, 4'b0001},
            // stall, then reset mid-stall restores pointer
            '{0, 1, 4'b1000, 0, 4'b0000, 1, 32'hA0, 4'b0001},
            '{0, 0, 4'b1111, 0, 4'b0000, 0, 32'h00, 4'b0000},
            '{0, 1, 4'b1111, 1, 4'b0001, 1, 32'hA0, 4'b0001},
            // fixed priority
            '{1, 0, 4'b0000, 1, 4'b0000, 0, 32'h00, 4'b0000},
            '{1, 1, 4'b1010, 1, 4'b0010, 1, 32'hA1, 4'b0010},
            '{1, 1, 4'b1010, 1, 4'b0010, 1, 32'hA1, 4'b0010},
            '{1, 1, 4'b1010, 1, 4'b0010, 1, 32'hA1, 4'b0010},
            '{1, 1, 4'b1111, 1, 4'b0001, 1, 32'hA0, 4'b0001},
            '{1, 1, 4'b1100, 1, 4'b0100, 1, 32'hA2, 4'b0100}
        };
        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].rst_n, tbl[i].v, tbl[i].wr);
            chk($sformatf("rdy[%0d]", i), {28'd0, tbl[i].f ? f_rdy : r_rdy}, {28'd0, tbl[i].rdy});
            sb.push_back('{tbl[i].f, tbl[i].wv, tbl[i].word, tbl[i].g});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("wv[%0d]", i), {31'd0, e.f ? f_wv : r_wv}, {31'd0, e.wv});
            chk($sformatf("word[%0d]", i), e.f ? f_word : r_word, e.word);
            chk($sformatf("grant[%0d]", i), {28'd0, e.f ? f_g : r_g}, {28'd0, e.g});
        end
        // single-channel variant behaves as a plain register stage
        drive(1'b0, 4'b0001, 1'b1);
        chk("one_rst_rdy", {31'd0, s_rdy}, 32'd0);
        @(posedge clk); #1;
        chk("one_rst_wv", {31'd0, s_wv}, 32'd0);
        chk("one_rst_word", s_word, 32'd0);
        drive(1'b1, 4'b0001, 1'b0);
        chk("one_rdy", {31'd0, s_rdy}, 32'd1);
        @(posedge clk); #1;
        chk("one_word", s_word, 32'h55);
        chk("one_grant", {31'd0, s_g}, 32'd1);
        drive(1'b1, 4'b0001, 1'b0);
        chk("one_stall_rdy", {31'd0, s_rdy}, 32'd0);
        drive(1'b1, 4'b0000, 1'b1);
        @(posedge clk); #1;
        chk("one_drain_wv", {31'd0, s_wv}, 32'd0);
        chk("one_hold_word", s_word, 32'h55);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/onehot_arbiter_mux.md
ONEHOT_ARBITER_MUX -- requirements
Module: onehot_arbiter_mux

Interface
REQ-001 Parameter: Count, default 4, number of request channels, legal range 1..16.
REQ-002 Parameter: Width, default 32, bits per data word, legal range 1..64.
REQ-003 Parameter: Mode, default ARB_ROUND_ROBIN, arbitration policy of type arb_mode_t (ARB_ROUND_ROBIN or ARB_FIXED).
REQ-004 Port: clk_i  input  1  sole clock; all state on rising edge.
REQ-005 Port: rst_ni  input  1  reset, synchronous and active-low.
REQ-006 Port: req_valid_i  input  Count  per-channel request valid.
REQ-007 Port: req_word_i  input  Width x Count (unpacked array [Count])  per-channel data word.
REQ-008 Port: req_ready_o  output  Count  per-channel accept; at most one bit high.
REQ-009 Port: word_valid_o  output  1  output register holds a word.
REQ-010 Port: word_o  output  Width  registered selected word.
REQ-011 Port: grant_o  output  Count  registered one-hot index of the channel that supplied word_o.
REQ-012 Port: word_ready_i  input  1  downstream accept.

Function
REQ-013 Single-entry output register; can_accept = !word_valid_o || word_ready_i.
REQ-014 Combinational grant vector: one-hot or zero; zero iff req_valid_i == 0.
REQ-015 req_ready_o = grant & {Count{can_accept}}; no dependency of req_ready_o on word_ready_i beyond can_accept.
REQ-016 Transfer on channel k when req_valid_i[k] && req_ready_o[k]; next cycle word_valid_o=1, word_o=req_word_i[k], grant_o bit k set (latency 1 cycle).
REQ-017 Data select via one-hot AND-OR mux; zero grant yields all-zero mux output.
REQ-018 Output consumed (word_valid_o && word_ready_i) with no new transfer: word_valid_o=0 next cycle; word_o and grant_o hold last values.
REQ-019 Simultaneous consume and transfer: new word loaded same edge, word_valid_o stays 1 (full throughput, one word per cycle).
REQ-020 word_valid_o=1 and word_ready_i=0: word_o, grant_o, word_valid_o stable; req_ready_o all zero.
REQ-021 ARB_FIXED: lowest-index valid channel wins; no pointer state.
REQ-022 ARB_ROUND_ROBIN: priority pointer (Count-bit one-hot) marks highest-priority channel; search wraps from pointer upward through Count-1 to 0.
REQ-023 Pointer updates only on a transfer: becomes channel after the granted one, wrapping Count-1 -> 0; unchanged on idle or stalled cycles.
REQ-024 Grant may change while stalled (req_ready_o=0); no grant lock before transfer.
REQ-025 Count=1: grant = req_valid_i[0]; pointer constant; behaves as a registered pipeline stage.
REQ-026 Channel deasserting valid before transfer is not an error; arbitration re-evaluates every cycle.

Reset
REQ-027 rst_ni=0 at a rising edge: word_valid_o=0, word_o=0, grant_o=0, pointer=channel 0; overrides any transfer that cycle.
REQ-028 req_ready_o held at zero while rst_ni=0.
REQ-029 Reset mid-stall discards held word; no transfer reported for it.

Structure
REQ-030 Shared package timewave_pkg (or existing shared package) holds arb_mode_t enum; no other new types.
REQ-031 Data selection instantiates existing onehot_mux sub-module (Count, Width) driven by grant; arbiter logic inline.
REQ-032 Formal bench onehot_arbiter_mux_tb binds to the module: asserts $onehot0(req_ready_o), $onehot0(grant_o), stability under stall, and eventual grant of persistently valid channel in ARB_ROUND_ROBIN within Count transfers.

Verification
REQ-033 Reset then idle: rst_ni low 2 cycles -> word_valid_o=0, word_o=0, grant_o=0, req_ready_o=0.
REQ-034 Count=4 RR, all valid, word_ready_i=1, words 0xA0..0xA3 -> grant_o sequence 0001,0010,0100,1000,0001; word_o 0xA0,0xA1,0xA2,0xA3,0xA0.
REQ-035 Count=4 FIXED, valid=1010 held 3 cycles -> grant_o 0010 every cycle; channel 3 never served.
REQ-036 Stall: word held with word_ready_i=0 for 5 cycles -> word_o/grant_o unchanged, req_ready_o=0000; release -> next word loaded same edge, word_valid_o stays 1.
REQ-037 Wrap: RR pointer at channel 3, valid=1001 -> channel 3 granted, then channel 0.
REQ-038 Reset mid-stall: rst_ni low one cycle with word_valid_o=1 -> word_valid_o=0, pointer back to channel 0 (valid=1111 next grants 0001).
